// File: rtl/dmem_access_unit.sv
// M-stage data-memory access unit: req/gnt/rvalid handshake, pipeline stall,
// wait-cycle timeout and the W-stage writeback registers.
`timescale 1ns/1ps
module dmem_access_unit #(
  parameter int unsigned DPW     = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [4:0]     RdM,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic [DPW-1:0] dmem_addr_o,
  output logic [DPW-1:0] dmem_wdata_o,
  input  logic           dmem_gnt_i,
  input  logic           dmem_rvalid_i,
  input  logic [DPW-1:0] dmem_rdata_i,
  output logic           stallM_o,
  output logic           regwriteW,
  output logic [DPW-1:0] resultW,
  output logic [4:0]     RdW,
  output logic           misalign_o,
  output logic           err_o
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;

  logic mem_op, is_store, aligned, timeout_hit;
  logic issue, pass, mis, done_store, done_load, abort, bubble;

  assign mem_op      = memwriteM | resultsrcM;
  assign is_store    = memwriteM;
  assign aligned     = (aluresultM[1:0] == 2'b00);
  assign timeout_hit = (state != IDLE) && (cnt == CNT_LAST);

  // Next state and per-cycle action; completion always wins over timeout.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    pass       = 1'b0;
    mis        = 1'b0;
    done_store = 1'b0;
    done_load  = 1'b0;
    abort      = 1'b0;
    bubble     = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          pass = 1'b1;
        end else if (!aligned) begin
          mis = 1'b1;
        end else begin
          issue = 1'b1;
          if (dmem_gnt_i && is_store) begin
            done_store = 1'b1;
          end else begin
            bubble   = 1'b1;
            state_nx = dmem_gnt_i ? RESP : REQ;
          end
        end
      end
      REQ: begin
        issue = 1'b1;
        if (dmem_gnt_i && is_store) begin
          done_store = 1'b1;
          state_nx   = IDLE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else begin
          bubble = 1'b1;
          if (dmem_gnt_i) state_nx = RESP;
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          done_load = 1'b1;
          state_nx  = IDLE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else begin
          bubble = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request is suppressed while reset is held so nothing leaks onto the bus.
  assign dmem_req_o   = issue & arst_n;
  assign dmem_we_o    = dmem_req_o & memwriteM;
  assign dmem_addr_o  = aluresultM;
  assign dmem_wdata_o = Rd2M;
  assign stallM_o     = bubble;

  // State, wait counter, fault pulses and W-stage registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      regwriteW  <= 1'b0;
      resultW    <= '0;
      RdW        <= '0;
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= (state == IDLE) ? '0 : cnt + CW'(1);
      misalign_o <= mis;
      err_o      <= abort;
      if (pass) begin
        regwriteW <= regwriteM;
        resultW   <= aluresultM;
        RdW       <= RdM;
      end else if (done_store) begin
        regwriteW <= 1'b0;
        RdW       <= RdM;
      end else if (done_load) begin
        regwriteW <= regwriteM;
        resultW   <= dmem_rdata_i;
        RdW       <= RdM;
      end else begin
        regwriteW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, reset corner cases and
// randomized transactions checked against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_access_unit;

  localparam int unsigned DPW = 32;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           regwriteM = 1'b0, resultsrcM = 1'b0, memwriteM = 1'b0;
  logic [DPW-1:0] aluresultM = '0, Rd2M = '0, dmem_rdata_i = '0;
  logic [4:0]     RdM = '0;
  logic           dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic           dmem_req_o, dmem_we_o, stallM_o, regwriteW, misalign_o, err_o;
  logic [DPW-1:0] dmem_addr_o, dmem_wdata_o, resultW;
  logic [4:0]     RdW;

  dmem_access_unit #(.DPW(DPW), .TIMEOUT(T)) dut (
    .clk(clk), .arst_n(arst_n),
    .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
    .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stallM_o(stallM_o), .regwriteW(regwriteW), .resultW(resultW), .RdW(RdW),
    .misalign_o(misalign_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, rs, mw;
    logic [31:0] addr, wd;
    logic [4:0]  rd;
    int          g, r;      // gnt after g request cycles, rvalid on response cycle r
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    int          stalls, reqs;
    logic        rww;
    logic [31:0] res;
    logic [4:0]  rdw;
    bit          chk_res, chk_rd;
    logic        mis, err;
  } exp_t;

  typedef struct { op_t o; exp_t e; } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic op_t mk_op(input logic rw, input logic rs, input logic mw,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [4:0] rd, input int g, input int r,
                                input logic [31:0] rdata);
    op_t o;
    o.rw = rw; o.rs = rs; o.mw = mw; o.addr = addr; o.wd = wd;
    o.rd = rd; o.g = g; o.r = r; o.rdata = rdata;
    return o;
  endfunction

  function automatic exp_t mk_exp(input int stalls, input int reqs, input logic rww,
                                  input logic [31:0] res, input logic [4:0] rdw,
                                  input bit chk_res, input bit chk_rd,
                                  input logic mis, input logic err);
    exp_t e;
    e.stalls = stalls; e.reqs = reqs; e.rww = rww; e.res = res; e.rdw = rdw;
    e.chk_res = chk_res; e.chk_rd = chk_rd; e.mis = mis; e.err = err;
    return e;
  endfunction

  // Transaction-level reference: outcome of one op from its handshake timing.
  function automatic exp_t model(input op_t o);
    exp_t e;
    int   tot;
    e = mk_exp(0, 0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!(o.mw | o.rs)) begin
      e.rww = o.rw; e.res = o.addr; e.rdw = o.rd; e.chk_res = 1'b1; e.chk_rd = 1'b1;
    end else if (o.addr[1:0] != 2'b00) begin
      e.mis = 1'b1;
    end else if (o.mw) begin
      if (o.g > T) begin
        e.stalls = T; e.reqs = T + 1; e.err = 1'b1;
      end else begin
        e.stalls = o.g; e.reqs = o.g + 1; e.rdw = o.rd; e.chk_rd = 1'b1;
      end
    end else begin
      tot = o.g + o.r + 1;
      if (tot > T) begin
        e.stalls = T; e.reqs = ((o.g < T) ? o.g : T) + 1; e.err = 1'b1;
      end else begin
        e.stalls = tot; e.reqs = o.g + 1; e.rww = o.rw; e.res = o.rdata;
        e.rdw = o.rd; e.chk_res = 1'b1; e.chk_rd = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic drive_nop(input logic [31:0] addr);
    regwriteM = 1'b0; resultsrcM = 1'b0; memwriteM = 1'b0;
    aluresultM = addr; Rd2M = '0; RdM = '0;
  endtask

  // Hold one op on the M inputs, respond on the bus, then check W stage.
  task automatic run_op(input op_t o, input exp_t e, input string tag);
    int cyc, stalls, reqs, resp_idx;
    bit resp_ph, done, sig_ok, bub_ok;
    cyc = 0; stalls = 0; reqs = 0; resp_idx = 0;
    resp_ph = 1'b0; done = 1'b0; sig_ok = 1'b1; bub_ok = 1'b1;
    @(negedge clk);
    regwriteM = o.rw; resultsrcM = o.rs; memwriteM = o.mw;
    aluresultM = o.addr; Rd2M = o.wd; RdM = o.rd;
    while (!done && cyc < 64) begin
      dmem_gnt_i = 1'b0;
      dmem_rdata_i = $urandom;
      dmem_rvalid_i = resp_ph ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (regwriteW !== 1'b0) bub_ok = 1'b0;
      if (dmem_req_o === 1'b1) begin
        if (dmem_we_o !== o.mw || dmem_addr_o !== o.addr || dmem_wdata_o !== o.wd)
          sig_ok = 1'b0;
        if (reqs == o.g) dmem_gnt_i = 1'b1;
        reqs++;
      end else if (dmem_we_o !== 1'b0) begin
        sig_ok = 1'b0;
      end
      if (resp_ph) begin
        if (resp_idx == o.r) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = o.rdata;
        end
        resp_idx++;
      end
      #1;
      if (stallM_o !== 1'b1) done = 1'b1;
      else stalls++;
      if (dmem_gnt_i && !o.mw) resp_ph = 1'b1;
      cyc++;
      if (!done) @(negedge clk);
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s:complete: got no completion, expected one within 64 cycles", tag);
    end
    check({tag, ":stalls"}, 32'(stalls), 32'(e.stalls));
    check({tag, ":reqs"}, 32'(reqs), 32'(e.reqs));
    check({tag, ":bus_sig"}, 32'(sig_ok), 32'd1);
    check({tag, ":bubble"}, 32'(bub_ok), 32'd1);
    @(negedge clk);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    check({tag, ":regwriteW"}, 32'(regwriteW), 32'(e.rww));
    if (e.chk_res) check({tag, ":resultW"}, resultW, e.res);
    if (e.chk_rd) check({tag, ":RdW"}, 32'(RdW), 32'(e.rdw));
    check({tag, ":misalign"}, 32'(misalign_o), 32'(e.mis));
    check({tag, ":err"}, 32'(err_o), 32'(e.err));
    drive_nop('0);
    @(negedge clk);
    check({tag, ":pulse_end"}, {30'd0, misalign_o, err_o}, 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    op_t o;
    int  kind, g, r;

    // Directed vectors: {op, expected outcome}.
    vecs[0]  = '{mk_op(1, 0, 0, 32'h1234, 0, 5, 0, 0, 0),             mk_exp(0, 0, 1, 32'h1234, 5, 1, 1, 0, 0)};
    vecs[1]  = '{mk_op(1, 1, 0, 32'h100, 0, 7, 0, 2, 32'hDEADBEEF),   mk_exp(3, 1, 1, 32'hDEADBEEF, 7, 1, 1, 0, 0)};
    vecs[2]  = '{mk_op(1, 0, 1, 32'h200, 32'hA5A5A5A5, 3, 3, 0, 0),   mk_exp(3, 4, 0, 0, 3, 0, 1, 0, 0)};
    vecs[3]  = '{mk_op(1, 1, 0, 32'h102, 0, 4, 0, 0, 0),              mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[4]  = '{mk_op(1, 1, 0, 32'h300, 0, 6, 0, 100, 0),            mk_exp(16, 1, 0, 0, 0, 0, 0, 0, 1)};
    vecs[5]  = '{mk_op(1, 1, 1, 32'h40, 32'h11, 8, 1, 0, 0),          mk_exp(1, 2, 0, 0, 8, 0, 1, 0, 0)};
    vecs[6]  = '{mk_op(0, 0, 1, 32'h44, 32'h22, 9, 0, 0, 0),          mk_exp(0, 1, 0, 0, 9, 0, 1, 0, 0)};
    vecs[7]  = '{mk_op(1, 1, 0, 32'h48, 0, 10, 2, 0, 32'h1),          mk_exp(3, 3, 1, 32'h1, 10, 1, 1, 0, 0)};
    vecs[8]  = '{mk_op(0, 1, 0, 32'h4C, 0, 11, 1, 1, 32'h55AA),       mk_exp(3, 2, 0, 32'h55AA, 11, 1, 1, 0, 0)};
    vecs[9]  = '{mk_op(1, 0, 1, 32'h201, 32'h33, 12, 0, 0, 0),        mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[10] = '{mk_op(1, 0, 1, 32'h50, 32'h44, 13, 20, 0, 0),        mk_exp(16, 17, 0, 0, 0, 0, 0, 0, 1)};
    vecs[11] = '{mk_op(1, 1, 0, 32'h54, 0, 14, 13, 2, 32'hBEEF),      mk_exp(16, 14, 1, 32'hBEEF, 14, 1, 1, 0, 0)};
    vecs[12] = '{mk_op(1, 1, 0, 32'h58, 0, 15, 13, 3, 32'hBEEF),      mk_exp(16, 14, 0, 0, 0, 0, 0, 0, 1)};

    // Reset: W registers clear and no request even with an aligned load presented.
    resultsrcM = 1'b1; aluresultM = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    check("rst:req", 32'(dmem_req_o), 32'd0);
    check("rst:wregs", {regwriteW, resultW[25:0], RdW}, 32'd0);
    check("rst:pulses", {30'd0, misalign_o, err_o}, 32'd0);
    drive_nop('0);
    @(negedge clk);
    arst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].o, vecs[i].e, $sformatf("vec%0d", i));

    // Reset in RESP: preload W, grant a load, reset mid-response, late rvalid/gnt.
    @(negedge clk);
    regwriteM = 1'b1; aluresultM = 32'hCAFE0004; RdM = 5'd9;
    @(negedge clk);
    regwriteM = 1'b1; resultsrcM = 1'b1; aluresultM = 32'h100; RdM = 5'd2;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    check("rstx:pre_result", resultW, 32'hCAFE0004);
    check("rstx:pre_stall", 32'(stallM_o), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    check("rstx:async_wregs", {regwriteW, resultW[25:0], RdW}, 32'd0);
    check("rstx:req_in_rst", 32'(dmem_req_o), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    drive_nop(32'h77);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555; dmem_gnt_i = 1'b1;
    #1;
    check("rstx:late_stall", 32'(stallM_o), 32'd0);
    check("rstx:late_req", 32'(dmem_req_o), 32'd0);
    @(negedge clk);
    dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
    check("rstx:late_result", resultW, 32'h77);
    check("rstx:late_regwrite", 32'(regwriteW), 32'd0);
    check("rstx:late_err", {30'd0, misalign_o, err_o}, 32'd0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 120; n++) begin
      kind = int'($urandom_range(0, 5));
      g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      o = mk_op(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, $urandom,
                5'($urandom), g, r, $urandom);
      case (kind)
        1, 5: begin o.rs = 1'b1; o.addr[1:0] = 2'b00; end
        2: begin o.mw = 1'b1; o.addr[1:0] = 2'b00; end
        3: begin o.mw = 1'b1; o.rs = 1'b1; o.addr[1:0] = 2'b00; end
        4: begin
          o.rs = 1'($urandom_range(0, 1));
          o.mw = ~o.rs;
          o.addr[1:0] = 2'($urandom_range(1, 3));
        end
        default: ;
      endcase
      run_op(o, model(o), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
